song_sequencer: RTL and testbench
=================================

// Module: song_sequencer
// PURPOSE
//  Plays a melody by stepping through an external note ROM, one entry at a time.
//  Drives a shared tone generator: the pitch divider value (tone_div) plus a gate (tone_en).
//  Each note is held for a programmable number of beats; an optional silence follows each note.
//  Started and stopped by a pulse interface. busy and done report status to the top level.
// PARAMETERS
//  TICKS_PER_BEAT  3000000  clk cycles per beat (0.25 s at 12 MHz)
//  SONG_LEN        25       number of ROM entries played, addresses 0..SONG_LEN-1
//  IDX_W           5        width of note_addr; requires 2**IDX_W >= SONG_LEN
//  GAP_TICKS       300000   silence cycles between notes (used only with the macro)
// PORTS
//  clk        in   1      system clock, 12 MHz
//  rst        in   1      synchronous reset, active-high
//  start      in   1      1-cycle pulse: begin the song at entry 0
//  stop       in   1      1-cycle pulse: abort playback
//  note_code  in   4      ROM data at note_addr (combinational ROM): pitch code
//  note_len   in   2      ROM data at note_addr: beats-1 (0..3 -> 1..4 beats)
//  note_addr  out  IDX_W  ROM address, registered
//  tone_div   out  16     clock divider value sent to the tone generator, registered
//  tone_en    out  1      tone gate: 1 = sound, 0 = silence
//  busy       out  1      high from the cycle after start until the cycle after the song ends or stop
//  done       out  1      1-cycle pulse when the last note has finished (not asserted on stop)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs are 0; tick and beat counters are 0.
//  Pitch table (note_code -> tone_div):
//   1=45977 (C)  2=40955 (D)  3=36474 (E)  4=34383 (F)  5=30612 (G)  6=27272 (A)
//   7=25751 (A#) 8=22944 (C5)
//   0 and 9..15 = rest: tone_div=0, tone_en=0.
//  FSM states: IDLE, FETCH, PLAY, GAP (macro only), FINISH.
//  IDLE:   start=1 -> FETCH; note_addr=0; busy=1.
//  FETCH:  lasts 1 cycle; tone_en=0.
//          Samples note_code and note_len at note_addr.
//          Loads tone_div from the pitch table; sets tone_en=1 if the code is a pitch.
//          beat_cnt=note_len; tick_cnt=TICKS_PER_BEAT-1. Next state is PLAY.
//  PLAY:   tick_cnt decrements every cycle. When tick_cnt=0: if beat_cnt>0, decrement beat_cnt
//          and reload tick_cnt; if beat_cnt=0, the note ends.
//          PLAY therefore lasts exactly (note_len+1)*TICKS_PER_BEAT cycles.
//  Note end: if note_addr==SONG_LEN-1 -> FINISH.
//          Otherwise note_addr increments -> FETCH (or -> GAP with the macro).
//          note_addr never exceeds SONG_LEN-1; there is no wrap-around.
//  FINISH: lasts 1 cycle. tone_en=0, done=1, busy=0, note_addr=0 -> IDLE.
//  tone_en is low during FETCH, so consecutive notes are separated by at least 1 silent cycle.
//  tone_div holds its last value until the next FETCH.
//  stop: in any state other than IDLE, the next state is IDLE.
//          tone_en=0, busy=0, done=0, note_addr=0, counters are cleared.
//          stop overrides a note end and overrides FINISH occurring in the same cycle.
//  start while busy is ignored. start and stop together in IDLE: stop wins, stay IDLE.
//  rst overrides everything, from any state, mid-note included.
// CONFIGURATION
//  Macro SEQ_ARTICULATION_GAP_EN:
//   Defined: a non-final note end goes to GAP instead of FETCH.
//     GAP holds tone_en=0 for exactly GAP_TICKS cycles, then goes to FETCH.
//     The last note goes straight to FINISH with no gap. stop during GAP -> IDLE.
//   Undefined: GAP state and GAP_TICKS counter logic are not built; GAP_TICKS is ignored.
// TESTING  (TICKS_PER_BEAT=4, SONG_LEN=3, GAP_TICKS=2; ROM = {C,0},{D,1},{0,0})
//  1. Reset: hold rst 3 cycles -> note_addr, tone_div, tone_en, busy, done all 0.
//  2. start pulse -> tone_en: 1 low (FETCH), 4 high @45977, 1 low, 8 high @40955,
//     1 low, 4 low (rest, tone_div=0) -> done high exactly 1 cycle.
//     busy falls with done; note_addr sequence is 0,1,2,0.
//  3. stop during cycle 3 of note D -> next cycle tone_en=0, busy=0, note_addr=0, done never pulses.
//     A new start replays from entry 0.
//  4. start pulse while busy during note C -> no effect: timing identical to test 2.
//     start and stop in the same cycle while in IDLE -> busy stays 0.
//  5. ROM entry 1 = {code 11, len 3} -> tone_en=0 and tone_div=0 for 16 cycles,
//     then playback continues normally.
//  6. SEQ_ARTICULATION_GAP_EN defined, repeat test 2 -> 2 extra low cycles after C and after D,
//     none after the rest. done arrives 4 cycles later than in test 2.

Source files
------------

// File: rtl/song_sequencer_if.sv
// Start/stop control, note ROM port and tone generator port of the song sequencer.
interface song_sequencer_if #(
  parameter int unsigned IDX_W = 5
);
  logic             start;
  logic             stop;
  logic [3:0]       note_code;
  logic [1:0]       note_len;
  logic [IDX_W-1:0] note_addr;
  logic [15:0]      tone_div;
  logic             tone_en;
  logic             busy;
  logic             done;

  modport master (
    input  start, stop, note_code, note_len,
    output note_addr, tone_div, tone_en, busy, done
  );

  modport slave (
    output start, stop, note_code, note_len,
    input  note_addr, tone_div, tone_en, busy, done
  );
endinterface

// File: rtl/song_sequencer.sv
// Melody player: walks a note ROM and drives a tone generator divider plus gate.
// Optional silence between notes: define SEQ_ARTICULATION_GAP_EN.
module song_sequencer #(
  parameter int unsigned TICKS_PER_BEAT = 3000000,
  parameter int unsigned SONG_LEN       = 25,
  parameter int unsigned IDX_W          = 5,
  parameter int unsigned GAP_TICKS      = 300000
) (
  input  logic                 clk,
  input  logic                 rst,
  song_sequencer_if.master     bus
);

  // One counter serves both beat ticks and the articulation gap
  localparam int unsigned TICK_MAX = (TICKS_PER_BEAT > GAP_TICKS) ? TICKS_PER_BEAT : GAP_TICKS;
  localparam int unsigned TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [IDX_W-1:0]  LAST_ADDR   = IDX_W'(SONG_LEN - 1);
  localparam logic [TICK_W-1:0] BEAT_RELOAD = TICK_W'(TICKS_PER_BEAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
`ifdef SEQ_ARTICULATION_GAP_EN
    GAP,
`endif
    FINISH
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   addr_q, addr_nxt;
  logic [15:0]        div_q, div_nxt;
  logic               en_q, en_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic [TICK_W-1:0]  tick_q, tick_nxt;
  logic [1:0]         beat_q, beat_nxt;

  function automatic logic [15:0] pitch_div(input logic [3:0] code);
    case (code)
      4'd1:    pitch_div = 16'd45977;
      4'd2:    pitch_div = 16'd40955;
      4'd3:    pitch_div = 16'd36474;
      4'd4:    pitch_div = 16'd34383;
      4'd5:    pitch_div = 16'd30612;
      4'd6:    pitch_div = 16'd27272;
      4'd7:    pitch_div = 16'd25751;
      4'd8:    pitch_div = 16'd22944;
      default: pitch_div = 16'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      div_q  <= '0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tick_q <= '0;
      beat_q <= '0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      div_q  <= div_nxt;
      en_q   <= en_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      tick_q <= tick_nxt;
      beat_q <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    div_nxt   = div_q;
    en_nxt    = en_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    tick_nxt  = tick_q;
    beat_nxt  = beat_q;

    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_nxt = FETCH;
          addr_nxt  = '0;
          busy_nxt  = 1'b1;
        end
      end
      FETCH: begin
        div_nxt   = pitch_div(bus.note_code);
        en_nxt    = (pitch_div(bus.note_code) != 16'd0);
        beat_nxt  = bus.note_len;
        tick_nxt  = BEAT_RELOAD;
        state_nxt = PLAY;
      end
      PLAY: begin
        if (tick_q != TICK_W'(0)) begin
          tick_nxt = tick_q - TICK_W'(1);
        end else if (beat_q != 2'd0) begin
          beat_nxt = beat_q - 2'd1;
          tick_nxt = BEAT_RELOAD;
        end else begin
          en_nxt = 1'b0;
          if (addr_q == LAST_ADDR) begin
            state_nxt = FINISH;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            addr_nxt  = '0;
          end else begin
            addr_nxt  = addr_q + IDX_W'(1);
`ifdef SEQ_ARTICULATION_GAP_EN
            state_nxt = GAP;
            tick_nxt  = TICK_W'(GAP_TICKS - 1);
`else
            state_nxt = FETCH;
`endif
          end
        end
      end
`ifdef SEQ_ARTICULATION_GAP_EN
      GAP: begin
        if (tick_q != TICK_W'(0)) tick_nxt = tick_q - TICK_W'(1);
        else                      state_nxt = FETCH;
      end
`endif
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Abort wins over any note end or finish decided above
    if (bus.stop && state != IDLE) begin
      state_nxt = IDLE;
      en_nxt    = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      addr_nxt  = '0;
      tick_nxt  = '0;
      beat_nxt  = '0;
    end
  end

  assign bus.note_addr = addr_q;
  assign bus.tone_div  = div_q;
  assign bus.tone_en   = en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed vector bench for song_sequencer with a 3-entry ROM and short beats.
module tb_song_sequencer;
  localparam int unsigned TPB   = 4;
  localparam int unsigned SLEN  = 3;
  localparam int unsigned IDXW  = 5;
  localparam int unsigned GAPT  = 2;
`ifdef SEQ_ARTICULATION_GAP_EN
  localparam int GAPX = 2;
`else
  localparam int GAPX = 0;
`endif

  typedef struct {
    logic        start;
    logic        stop;
    logic        en;
    logic [15:0] div;
    logic        busy;
    logic        done;
    logic [4:0]  addr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] rom_code [32];
  logic [1:0] rom_len  [32];
  vec_t q[$];
  int checks = 0;
  int errors = 0;

  song_sequencer_if #(.IDX_W(IDXW)) bus ();

  song_sequencer #(
    .TICKS_PER_BEAT(TPB), .SONG_LEN(SLEN), .IDX_W(IDXW), .GAP_TICKS(GAPT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  assign bus.note_code = rom_code[bus.note_addr];
  assign bus.note_len  = rom_len[bus.note_addr];

  always #5 clk = ~clk;

  function automatic logic [23:0] pack(input logic en, input logic [15:0] div,
                                       input logic busy, input logic done, input logic [4:0] addr);
    pack = {en, div, busy, done, addr};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got en=%0b div=%0d busy=%0b done=%0b addr=%0d, want en=%0b div=%0d busy=%0b done=%0b addr=%0d",
               name, act[23], act[22:7], act[6], act[5], act[4:0],
               exp[23], exp[22:7], exp[6], exp[5], exp[4:0]);
    end
  endtask

  function automatic logic [23:0] dut_out();
    dut_out = pack(bus.tone_en, bus.tone_div, bus.busy, bus.done, bus.note_addr);
  endfunction

  task automatic seg(input int n, input logic en, input logic [15:0] div,
                     input logic busy, input logic done, input logic [4:0] addr);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.start = 1'b0; v.stop = 1'b0;
      v.en = en; v.div = div; v.busy = busy; v.done = done; v.addr = addr;
      q.push_back(v);
    end
  endtask

  // Expected trace of the default song {C,0},{D,1},{rest,0}, one entry per cycle
  task automatic build_song();
    q.delete();
    seg(1, 1'b0, 16'd0, 1'b1, 1'b0, 5'd0);
    q[0].start = 1'b1;
    seg(4,        1'b1, 16'd45977, 1'b1, 1'b0, 5'd0);
    seg(1 + GAPX, 1'b0, 16'd45977, 1'b1, 1'b0, 5'd1);
    seg(8,        1'b1, 16'd40955, 1'b1, 1'b0, 5'd1);
    seg(1 + GAPX, 1'b0, 16'd40955, 1'b1, 1'b0, 5'd2);
    seg(4,        1'b0, 16'd0,     1'b1, 1'b0, 5'd2);
    seg(1,        1'b0, 16'd0,     1'b0, 1'b1, 5'd0);
    seg(2,        1'b0, 16'd0,     1'b0, 1'b0, 5'd0);
  endtask

  task automatic run_vectors(input string tag);
    for (int i = 0; i < q.size(); i++) begin
      bus.start = q[i].start;
      bus.stop  = q[i].stop;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      check($sformatf("%s[%0d]", tag, i), dut_out(),
            pack(q[i].en, q[i].div, q[i].busy, q[i].done, q[i].addr));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rom_code[i] = 4'd0;
      rom_len[i]  = 2'd0;
    end
    rom_code[0] = 4'd1; rom_len[0] = 2'd0;
    rom_code[1] = 4'd2; rom_len[1] = 2'd1;
    rom_code[2] = 4'd0; rom_len[2] = 2'd0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    // Reset held three cycles
    repeat (3) @(posedge clk);
    #1;
    check("reset", dut_out(), 24'd0);
    rst = 1'b0;

    // Full song
    build_song();
    run_vectors("song");

    // Stop during third cycle of note D, then watch for a stray done
    build_song();
    q = q[0 : 8 + GAPX];
    seg(1, 1'b0, 16'd40955, 1'b0, 1'b0, 5'd0);
    q[q.size() - 1].stop = 1'b1;
    seg(6, 1'b0, 16'd40955, 1'b0, 1'b0, 5'd0);
    run_vectors("stop");

    // Replay after stop starts from entry 0; divider still holds D
    build_song();
    q[0].div = 16'd40955;
    run_vectors("replay");

    // Start while busy is ignored
    build_song();
    q[2].start = 1'b1;
    run_vectors("restart_busy");

    // Start and stop together in IDLE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("start_stop_idle0", dut_out(), 24'd0);
    @(posedge clk);
    #1;
    check("start_stop_idle1", dut_out(), 24'd0);

    // Unknown code 11 held four beats plays as silence
    rom_code[1] = 4'd11; rom_len[1] = 2'd3;
    q.delete();
    seg(1, 1'b0, 16'd0, 1'b1, 1'b0, 5'd0);
    q[0].start = 1'b1;
    seg(4,        1'b1, 16'd45977, 1'b1, 1'b0, 5'd0);
    seg(1 + GAPX, 1'b0, 16'd45977, 1'b1, 1'b0, 5'd1);
    seg(16,       1'b0, 16'd0,     1'b1, 1'b0, 5'd1);
    seg(1 + GAPX, 1'b0, 16'd0,     1'b1, 1'b0, 5'd2);
    seg(4,        1'b0, 16'd0,     1'b1, 1'b0, 5'd2);
    seg(1,        1'b0, 16'd0,     1'b0, 1'b1, 5'd0);
    seg(2,        1'b0, 16'd0,     1'b0, 1'b0, 5'd0);
    run_vectors("rest_code");
    rom_code[1] = 4'd2; rom_len[1] = 2'd1;

    // Reset in the middle of note C
    build_song();
    q = q[0:2];
    run_vectors("pre_rst");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_note_rst", dut_out(), 24'd0);
    @(posedge clk);
    #1;
    check("post_rst_idle", dut_out(), 24'd0);

    build_song();
    run_vectors("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
